// File: rtl/vga_pkg.sv
// 640x480@60 timing constants, colour widths and default frame-buffer geometry
// shared by the VGA blocks.
package vga_pkg;

  localparam int c_pxl_visible  = 640;
  localparam int c_pxl_fporch   = 16;
  localparam int c_pxl_synch    = 96;
  localparam int c_pxl_total    = 800;

  localparam int c_line_visible = 480;
  localparam int c_line_fporch  = 10;
  localparam int c_line_synch   = 2;
  localparam int c_line_total   = 525;

  localparam logic c_synch_act  = 1'b0;

  localparam int c_nb_red   = 4;
  localparam int c_nb_green = 4;
  localparam int c_nb_blue  = 4;

  localparam int c_img_cols = 160;
  localparam int c_img_rows = 120;
  localparam int c_nb_addr  = 15;

  // Position inside the 4-clock pixel period; mirrors the vga_sync divider.
  typedef enum logic [1:0] {
    PH_READ = 2'd0,
    PH_ADDR = 2'd1,
    PH_DATA = 2'd2,
    PH_LOAD = 2'd3
  } phase_e;

endpackage

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port frame-buffer RAM between one display read per pixel and a
// held-request pixel writer; display latency 4 clocks, writes 1 clock after request.
module vga_fb_arbiter #(
  parameter int   c_img_cols  = vga_pkg::c_img_cols,
  parameter int   c_img_rows  = vga_pkg::c_img_rows,
  parameter int   c_nb_addr   = vga_pkg::c_nb_addr,
  parameter int   c_nb_red    = vga_pkg::c_nb_red,
  parameter int   c_nb_green  = vga_pkg::c_nb_green,
  parameter int   c_nb_blue   = vga_pkg::c_nb_blue,
  parameter logic c_synch_act = vga_pkg::c_synch_act
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    new_pxl,
  input  logic                                    visible,
  input  logic                                    hsync_in,
  input  logic                                    vsync_in,
  input  logic [9:0]                              col,
  input  logic [9:0]                              row,
  input  logic                                    wr_req,
  input  logic [c_nb_addr-1:0]                    wr_addr,
  input  logic [c_nb_red+c_nb_green+c_nb_blue-1:0] wr_data,
  output logic                                    wr_ack,
  output logic                                    wr_oor,
  output logic [c_nb_addr-1:0]                    mem_addr,
  output logic                                    mem_we,
  output logic [c_nb_red+c_nb_green+c_nb_blue-1:0] mem_wdata,
  input  logic [c_nb_red+c_nb_green+c_nb_blue-1:0] mem_rdata,
  output logic [c_nb_red-1:0]                     red,
  output logic [c_nb_green-1:0]                   green,
  output logic [c_nb_blue-1:0]                    blue,
  output logic                                    hsync,
  output logic                                    vsync
);

  import vga_pkg::*;

  localparam int c_nb_rgb   = c_nb_red + c_nb_green + c_nb_blue;
  localparam int c_img_size = c_img_cols * c_img_rows;
  localparam logic [c_nb_addr-1:0] c_cols_a = c_nb_addr'(c_img_cols);

  phase_e                 ph_q, ph_d;
  logic [c_nb_addr-1:0]   mem_addr_q, mem_addr_d;
  logic                   mem_we_q, mem_we_d;
  logic [c_nb_rgb-1:0]    mem_wdata_q, mem_wdata_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   wr_oor_q, wr_oor_d;
  logic                   need_q, need_d;
  logic [c_nb_rgb-1:0]    pix_buf_q, pix_buf_d;
  logic [c_nb_rgb-1:0]    colour_q, colour_d;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;

  logic                   disp_need;
  logic [c_nb_addr-1:0]   disp_addr;
  logic                   wr_in_range;

  assign disp_need   = visible && (32'(col) < 32'(c_img_cols)) && (32'(row) < 32'(c_img_rows));
  // Constant multiplier: reduces to shift-and-add, modulo 2**c_nb_addr.
  assign disp_addr   = c_nb_addr'(row) * c_cols_a + c_nb_addr'(col);
  assign wr_in_range = 32'(wr_addr) < 32'(c_img_size);

  always_comb begin
    ph_d        = new_pxl ? PH_READ : phase_e'(ph_q + 2'd1);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    wr_oor_d    = 1'b0;
    need_d      = need_q;
    pix_buf_d   = pix_buf_q;
    colour_d    = colour_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;

    if (ph_q == PH_READ && disp_need) begin
      mem_addr_d = disp_addr;
    end else if (wr_req && !wr_ack_q) begin
      // The ack cycle never grants, so a held request cannot be written twice.
      wr_ack_d = 1'b1;
      if (wr_in_range) begin
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
        mem_we_d    = 1'b1;
      end else begin
        wr_oor_d = 1'b1;
      end
    end

    if (ph_q == PH_READ) need_d = disp_need;
    if (ph_q == PH_DATA) pix_buf_d = mem_rdata;

    if (new_pxl) begin
      colour_d = need_q ? pix_buf_q : '0;
      hsync_d  = hsync_in;
      vsync_d  = vsync_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q        <= PH_READ;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_ack_q    <= 1'b0;
      wr_oor_q    <= 1'b0;
      need_q      <= 1'b0;
      pix_buf_q   <= '0;
      colour_q    <= '0;
      hsync_q     <= ~c_synch_act;
      vsync_q     <= ~c_synch_act;
    end else begin
      ph_q        <= ph_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      wr_oor_q    <= wr_oor_d;
      need_q      <= need_d;
      pix_buf_q   <= pix_buf_d;
      colour_q    <= colour_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign wr_oor    = wr_oor_q;
  assign red       = colour_q[c_nb_rgb-1 -: c_nb_red];
  assign green     = colour_q[c_nb_green+c_nb_blue-1 -: c_nb_green];
  assign blue      = colour_q[c_nb_blue-1:0];
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench: behavioural vga_sync timing and synchronous RAM around vga_fb_arbiter.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_pxl, visible, hsync_in, vsync_in;
  logic [9:0]  col, row;
  logic        wr_req;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack, wr_oor;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync;

  logic [11:0] ram [0:32767];

  int checks = 0;
  int fails  = 0;
  int div, pc, pr;
  bit sat;
  bit prev_ack;
  int w_addr, w_cnt, slot_err, dbl_err, slots_seen;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst(rst), .new_pxl(new_pxl), .visible(visible),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .col(col), .row(row),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_oor(wr_oor), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  // Frame buffer: preloaded with addr[11:0] while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 12'(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [11:0] pat(input int a);
    return 12'(a * 7 + 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    new_pxl  = (div == 3);
    col      = 10'(pc);
    row      = 10'(pr);
    visible  = (pc < 640) && (pr < 480);
    hsync_in = !((pc >= 656) && (pc < 752));
    vsync_in = !((pr >= 490) && (pr < 492));
  endtask

  task automatic step();
    bit rs;
    int ra;
    rs = (div == 0) && (pc < 160) && (pr < 120);
    ra = pr * 160 + pc;
    @(posedge clk);
    #1;
    if (sat) begin
      if (rs) begin
        slots_seen++;
        if (mem_we || (32'(mem_addr) != 32'(ra))) slot_err++;
      end
      if (wr_ack && prev_ack) dbl_err++;
      prev_ack = wr_ack;
      if (wr_ack) begin
        w_cnt++;
        w_addr++;
        if (w_addr == 19200) wr_req = 1'b0;
        else begin
          wr_addr = 15'(w_addr);
          wr_data = pat(w_addr);
        end
      end
    end
    if (div == 3) begin
      div = 0;
      pc++;
      if (pc == 800) begin
        pc = 0;
        pr++;
        if (pr == 525) pr = 0;
      end
    end else begin
      div++;
    end
    drive();
  endtask

  task automatic wait_at(input int c, input int r, input int d);
    int n = 0;
    while (!(pc == c && pr == r && div == d) && n < 6000) begin
      step();
      n++;
    end
    chk("reach_pixel", 32'(pc == c && pr == r && div == d), 32'd1);
  endtask

  initial begin
    int n;
    int bad;
    rst = 1'b1;
    div = 0; pc = 3; pr = 3;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    sat = 1'b0; prev_ack = 1'b0;
    w_addr = 0; w_cnt = 0; slot_err = 0; dbl_err = 0; slots_seen = 0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_ack_oor", 32'({wr_ack, wr_oor}), 32'd0);
    chk("rst_colour", 32'({red, green, blue}), 32'd0);
    chk("rst_syncs", 32'({hsync, vsync}), 32'd3);
    rst = 1'b0;

    wait_at(5, 3, 0);
    repeat (4) step();
    chk("pix_5_3", 32'({red, green, blue}), 32'h1E5);

    wait_at(159, 3, 0);
    repeat (4) step();
    chk("pix_159_3", 32'({red, green, blue}), 32'h27F);

    wait_at(160, 3, 0);
    step();
    chk("no_read_160", 32'(mem_addr), 32'h27F);
    repeat (3) step();
    chk("pix_160_3", 32'({red, green, blue}), 32'd0);

    wait_at(200, 3, 0);
    repeat (4) step();
    chk("pix_200_3", 32'({red, green, blue}), 32'd0);

    wait_at(656, 3, 0);
    repeat (3) step();
    chk("hsync_before", 32'(hsync), 32'd1);
    step();
    chk("hsync_fall", 32'(hsync), 32'd0);
    chk("vsync_line3", 32'(vsync), 32'd1);

    wr_req = 1'b1; wr_addr = 15'd19200; wr_data = 12'hABC;
    step();
    chk("oor_ack", 32'({wr_ack, wr_oor, mem_we}), 32'b110);
    wr_addr = 15'd19199; wr_data = 12'h5A5;
    step();
    chk("no_back_to_back", 32'(wr_ack), 32'd0);
    step();
    chk("last_ack", 32'({wr_ack, wr_oor, mem_we}), 32'b101);
    chk("last_addr", 32'(mem_addr), 32'd19199);
    chk("last_wdata", 32'(mem_wdata), 32'h5A5);
    wr_req = 1'b0;
    step();
    chk("ack_pulse", 32'({wr_ack, mem_we}), 32'd0);
    chk("ram_19199", 32'(ram[19199]), 32'h5A5);

    wait_at(20, 4, 0);
    wr_req = 1'b1; wr_addr = 15'd100; wr_data = 12'h777;
    step();
    chk("coll_read_addr", 32'(mem_addr), 32'h294);
    chk("coll_deferred", 32'({wr_ack, mem_we}), 32'd0);
    step();
    chk("coll_write", 32'({wr_ack, mem_we}), 32'b11);
    chk("coll_waddr", 32'(mem_addr), 32'd100);
    wr_req = 1'b0;
    repeat (2) step();
    chk("coll_pixel", 32'({red, green, blue}), 32'h294);

    step();
    w_addr = 0; w_cnt = 0; prev_ack = 1'b0;
    wr_addr = 15'd0; wr_data = pat(0); wr_req = 1'b1;
    sat = 1'b1;
    n = 0;
    while (wr_req && n < 60000) begin
      step();
      n++;
    end
    sat = 1'b0;
    wr_req = 1'b0;
    step();
    chk("sat_writes", 32'(w_cnt), 32'd19200);
    chk("sat_slot_we", 32'(slot_err), 32'd0);
    chk("sat_slots_seen", 32'(slots_seen > 0), 32'd1);
    chk("sat_double_ack", 32'(dbl_err), 32'd0);
    bad = 0;
    for (int i = 0; i < 19200; i++) if (ram[i] !== pat(i)) bad++;
    chk("sat_readback", 32'(bad), 32'd0);

    wr_addr = 15'd50; wr_data = 12'h123; wr_req = 1'b1;
    n = 0;
    while (!wr_ack && n < 10) begin
      step();
      n++;
    end
    chk("mid_ack_seen", 32'({wr_ack, mem_we}), 32'b11);
    rst = 1'b1;
    #1;
    chk("async_rst_ack", 32'({wr_ack, mem_we, wr_oor}), 32'd0);
    chk("async_rst_addr", 32'(mem_addr), 32'd0);
    chk("async_rst_out", 32'({red, green, blue, hsync, vsync}), 32'd3);
    wr_req = 1'b0;
    div = 0; pc = 0; pr = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("post_rst_read00", 32'({mem_addr, mem_we, wr_ack}), 32'd0);
    repeat (4) step();
    chk("post_rst_read10", 32'(mem_addr), 32'd1);
    repeat (3) step();
    chk("post_rst_pix10", 32'({red, green, blue}), 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
